// File: rtl/sort_ctrl_pkg.sv
// Shared types and helpers for the sorting-network sequencer.
// Widths here are the global data/index widths used by the whole network.
package sort_ctrl_pkg;

   localparam int NETWORK_WIDTH = 16;
   localparam int INDEX_WIDTH   = 4;

   typedef enum logic [2:0] {
      FILL,
      CLEAR,
      FIRE,
      WAIT,
      CAPTURE,
      DRAIN
   } ctrl_state_t;

   // Stage count of a bitonic network over n lanes.
   function automatic int bitonic_stages(input int n);
      int l;
      l = $clog2(n);
      return (l * (l + 1)) / 2;
   endfunction

   function automatic int data_lsb(input int lane);
      return lane * NETWORK_WIDTH;
   endfunction

   function automatic int index_lsb(input int lane);
      return lane * INDEX_WIDTH;
   endfunction

endpackage

// File: rtl/sort_stage_watchdog.sv
// Per-stage wait timer: cleared when a stage fires, counts while enabled,
// and flags expiry on the last allowed wait cycle.
module sort_stage_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] timer_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_reg <= '0;
      end else if (clear) begin
         timer_reg <= '0;
      end else if (enable) begin
         timer_reg <= timer_reg + 1'b1;
      end
   end

   assign expired = enable && (timer_reg == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sort_network_ctrl.sv
// Sequencer for a registered compare-exchange sorting network: gathers a batch,
// fires each stage in turn, captures the result and streams it out.
module sort_network_ctrl
   import sort_ctrl_pkg::*;
#(
   parameter int NUM_ELEMS      = 8,
   parameter int NUM_STAGES     = bitonic_stages(8),
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NETWORK_WIDTH-1:0]           in_data,
   output logic                               net_clear,
   output logic [NUM_STAGES-1:0]              net_stage_ready,
   input  logic [NUM_STAGES-1:0]              net_stage_done,
   output logic [NUM_ELEMS*NETWORK_WIDTH-1:0] net_data_in,
   output logic [NUM_ELEMS*INDEX_WIDTH-1:0]   net_index_in,
   input  logic [NUM_ELEMS*NETWORK_WIDTH-1:0] net_data_out,
   input  logic [NUM_ELEMS*INDEX_WIDTH-1:0]   net_index_out,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NETWORK_WIDTH-1:0]           out_data,
   output logic [INDEX_WIDTH-1:0]             out_index,
   output logic                               busy,
   output logic                               err_timeout
);

   localparam int CW = $clog2(NUM_ELEMS);
   localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CW-1:0] LAST_LANE  = CW'(NUM_ELEMS - 1);
   localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

   ctrl_state_t state_reg, state_next;

   logic [CW-1:0] wr_cnt_reg;
   logic [CW-1:0] rd_cnt_reg;
   logic [CW-1:0] rd_cnt_inc;
   logic [SW-1:0] stage_reg;
   logic          abort_reg;
   logic          err_timeout_reg;

   logic [NETWORK_WIDTH-1:0] ibuf [NUM_ELEMS];
   logic [INDEX_WIDTH-1:0]   iidx [NUM_ELEMS];
   logic [NETWORK_WIDTH-1:0] obuf [NUM_ELEMS];
   logic [INDEX_WIDTH-1:0]   oidx [NUM_ELEMS];

   logic [NETWORK_WIDTH-1:0] out_data_reg;
   logic [INDEX_WIDTH-1:0]   out_index_reg;

   logic in_fire;
   logic out_fire;
   logic stage_done;
   logic wd_clear;
   logic wd_enable;
   logic wd_expired;

   assign in_fire    = in_valid && (state_reg == FILL);
   assign out_fire   = out_ready && (state_reg == DRAIN);
   assign stage_done = net_stage_done[stage_reg];
   assign wd_clear   = (state_reg == FIRE);
   assign wd_enable  = (state_reg == WAIT) && !stage_done;
   assign rd_cnt_inc = rd_cnt_reg + 1'b1;

   sort_stage_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear),
      .enable (wd_enable),
      .expired(wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= FILL;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      in_ready        = 1'b0;
      net_clear       = 1'b0;
      net_stage_ready = '0;
      out_valid       = 1'b0;
      busy            = 1'b1;
      case (state_reg)
         FILL: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_fire && (wr_cnt_reg == LAST_LANE)) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            net_clear  = 1'b1;
            // An aborted batch only needs the network flushed, not re-run.
            state_next = abort_reg ? FILL : FIRE;
         end
         FIRE: begin
            net_stage_ready = NUM_STAGES'(1) << stage_reg;
            state_next      = WAIT;
         end
         WAIT: begin
            if (stage_done) begin
               state_next = (stage_reg == LAST_STAGE) ? CAPTURE : FIRE;
            end else if (wd_expired) begin
               state_next = CLEAR;
            end
         end
         CAPTURE: begin
            state_next = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_fire && (rd_cnt_reg == LAST_LANE)) begin
               state_next = FILL;
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_cnt_reg      <= '0;
         rd_cnt_reg      <= '0;
         stage_reg       <= '0;
         abort_reg       <= 1'b0;
         err_timeout_reg <= 1'b0;
         out_data_reg    <= '0;
         out_index_reg   <= '0;
      end else begin
         // NUM_ELEMS is a power of two, so the write pointer wraps naturally.
         if (in_fire) begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
         end
         case (state_reg)
            CLEAR: begin
               stage_reg <= '0;
               abort_reg <= 1'b0;
            end
            WAIT: begin
               if (stage_done) begin
                  if (stage_reg != LAST_STAGE) begin
                     stage_reg <= stage_reg + 1'b1;
                  end
               end else if (wd_expired) begin
                  abort_reg       <= 1'b1;
                  err_timeout_reg <= 1'b1;
                  wr_cnt_reg      <= '0;
               end
            end
            CAPTURE: begin
               // Lane 0 goes straight to the output register so DRAIN starts valid.
               rd_cnt_reg    <= '0;
               out_data_reg  <= net_data_out[data_lsb(0) +: NETWORK_WIDTH];
               out_index_reg <= net_index_out[index_lsb(0) +: INDEX_WIDTH];
            end
            DRAIN: begin
               if (out_fire) begin
                  rd_cnt_reg <= rd_cnt_inc;
                  if (rd_cnt_reg != LAST_LANE) begin
                     out_data_reg  <= obuf[rd_cnt_inc];
                     out_index_reg <= oidx[rd_cnt_inc];
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ELEMS; i++) begin
            ibuf[i] <= '0;
            iidx[i] <= '0;
            obuf[i] <= '0;
            oidx[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ELEMS; i++) begin
            if (in_fire && (wr_cnt_reg == CW'(i))) begin
               ibuf[i] <= in_data;
               iidx[i] <= INDEX_WIDTH'(wr_cnt_reg);
            end
            if (state_reg == CAPTURE) begin
               obuf[i] <= net_data_out[data_lsb(i) +: NETWORK_WIDTH];
               oidx[i] <= net_index_out[index_lsb(i) +: INDEX_WIDTH];
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_lane
         assign net_data_in[data_lsb(gi) +: NETWORK_WIDTH] = ibuf[gi];
         assign net_index_in[index_lsb(gi) +: INDEX_WIDTH] = iidx[gi];
      end
   endgenerate

   assign out_data    = out_data_reg;
   assign out_index   = out_index_reg;
   assign err_timeout = err_timeout_reg;

endmodule
